// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, slice width and a reference add/sub model.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  // Returns {cout, s} in the low w+1 bits for operands of width w (1..64).
  function automatic logic [64:0] golden_addsub(input logic [63:0] a, input logic [63:0] b,
                                                 input logic sub, input int w);
    logic [64:0] m, bx, sum;
    m = (65'd1 << w) - 65'd1;
    bx = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    sum = ({1'b0, a} & m) + bx + 65'(sub);
    return sum & ((m << 1) | 65'd1);
  endfunction
endpackage

// File: rtl/serial_addsub_slice.sv
// nibble_addsub_slice: combinational 4-bit adder/subtractor with carry chain ports.
module nibble_addsub_slice
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub_notadd,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W-1:0] bx;
  assign bx = sub_notadd ? ~b : b;
  assign {cout, s} = {1'b0, a} + {1'b0, bx} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: wide add/sub run through one 4-bit slice, LS nibble first,
// one nibble per clock, with valid/ready on both sides.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    sub_notadd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                    cout,
  output logic                    overflow
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_nx;
  logic [W-1:0] a_q, b_q;
  logic sub_q, carry, c4, last;
  logic [IW-1:0] idx;
  logic [NIBBLE_W-1:0] a4, b4, bx4, s4;
  assign a4 = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b4 = b_q[idx*NIBBLE_W +: NIBBLE_W];
  assign bx4 = sub_q ? ~b4 : b4;
  assign last = idx == IW'(NIBBLES - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  nibble_addsub_slice u_slice (
    .a(a4), .b(b4), .sub_notadd(sub_q), .cin(carry), .s(s4), .cout(c4)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      s <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
      sub_q <= sub_notadd;
      carry <= sub_notadd;
      idx <= '0;
    end else if (state == RUN) begin
      s[idx*NIBBLE_W +: NIBBLE_W] <= s4;
      carry <= c4;
      idx <= last ? '0 : idx + 1'b1;
      // MSB slice decides the flags
      if (last) begin
        cout <= c4;
        overflow <= (a4[NIBBLE_W-1] == bx4[NIBBLE_W-1]) && (s4[NIBBLE_W-1] != a4[NIBBLE_W-1]);
      end
    end
  end
endmodule
